pmem_loader: RTL and testbench
==============================

Name: pmem_loader

Overview:
- Writer end of the 14-bit program memory for the PIC16F1826 core; the core's fetch path is the reader.
- Accepts an ICSP-style serial command/data stream and writes 14-bit instruction words into a writable program memory at an 11-bit address.
- Holds the CPU off the memory while programming is active.
- Sits between the external programming pins and the program memory write port.

Parameters:
- PROG_CYCLES, 8, clk cycles busy after each write strobe (models the flash write time); legal range 1..255.
- SYNC_STAGES, 2, synchroniser depth for the serial pins; legal range 2..3.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Prog_en_in  input  1  programming mode enable (MCLR/Vpp equivalent); level-sensitive.
- Sclk_in  input  1  serial clock from programmer, asynchronous to clk.
- Sdata_in  input  1  serial data from programmer, asynchronous to clk, LSB first.
- Pmem_addr_out  output  11  program memory write address.
- Pmem_data_out  output  14  program memory write data.
- Pmem_we_out  output  1  one-cycle write strobe.
- Cpu_hold_out  output  1  high whenever Prog_en_in is high (synchronised); stalls the core.
- Busy_out  output  1  high during the write wait period.

Behaviour:
- Reset (async, rst_n=0): Pmem_addr_out=0, Pmem_data_out=0, Pmem_we_out=0, Cpu_hold_out=0, Busy_out=0, state=IDLE, shift counter=0, wait counter=0.
- Sclk_in, Sdata_in and Prog_en_in each pass through SYNC_STAGES flops. Sclk rising edges are detected on the synchronised signal, and Sdata is sampled on the same clk cycle as the detected edge.
- States:
  - IDLE: entered while Prog_en_in (synchronised) is 0. Clears the address and the shift counter. Moves to CMD when Prog_en_in goes to 1. Cpu_hold_out follows Prog_en_in with SYNC_STAGES cycles of latency.
  - CMD: shifts 6 bits LSB first. On the 6th bit, decodes in the same cycle:
    - 0x02 LOAD_DATA -> DATA.
    - 0x06 INC_ADDR -> address+1, wraps 0x7FF->0x000, stay in CMD.
    - 0x16 RESET_ADDR -> address=0, stay in CMD.
    - 0x08 BEGIN_PROG -> PROG.
    - Any other code -> ignored, stay in CMD.
  - DATA: shifts 16 bits LSB first: a start bit, 14 data bits, then a stop bit. Start and stop bit values are ignored. Bits 1..14 go into the data latch. After the 16th bit, Pmem_data_out updates and the state returns to CMD.
  - PROG: Pmem_we_out=1 for exactly one clk cycle, with the current Pmem_addr_out and Pmem_data_out. Next state is WAIT.
  - WAIT: Busy_out=1. The counter loads PROG_CYCLES-1 and decrements; when it reaches 0, Busy_out falls in the same cycle as the return to CMD. Sclk edges during WAIT are discarded, and no bits are shifted.
- Address and data are registered. The write strobe is never asserted outside PROG.
- Prog_en_in deasserting in any state: next cycle goes to IDLE. Any partial shift is dropped, Pmem_we_out is forced 0, and Busy_out is forced 0. A write strobe already issued is not retracted.
- Pmem_data_out holds its last loaded value across commands and is cleared only by reset. A second LOAD_DATA overwrites it.
- Sclk edges arriving closer than SYNC_STAGES+1 clk cycles apart are out of spec; behaviour is not defined.

Test Plan:
- Reset with Prog_en_in=1 and Sclk_in toggling -> all outputs 0. After release, Cpu_hold_out=1 within 3 cycles and the state is CMD.
- RESET_ADDR, then LOAD_DATA with word 0x2805, then BEGIN_PROG -> one Pmem_we_out pulse with addr=0x000 and data=0x2805. Busy_out is high for exactly 8 cycles.
- Load 0x3400 at addr 0, INC_ADDR, load 0x0103, program each -> two strobes: (0x000, 0x3400) and (0x001, 0x0103).
- RESET_ADDR, then 2047 INC_ADDR -> addr=0x7FF. One more INC_ADDR -> addr=0x000.
- Illegal command 0x3F, then BEGIN_PROG -> no state change from 0x3F. Strobe writes the previously loaded data.
- Drop Prog_en_in after 7 bits of a data frame -> no strobe, data unchanged, state IDLE. Re-enable with a full LOAD_DATA/BEGIN_PROG sequence -> correct write at addr 0.

Source files
------------

// File: rtl/pmem_loader_if.sv
// Bundle between the ICSP programming pins, the loader and the program memory write port.
interface pmem_loader_if;
  logic        Prog_en_in;
  logic        Sclk_in;
  logic        Sdata_in;
  logic [10:0] Pmem_addr_out;
  logic [13:0] Pmem_data_out;
  logic        Pmem_we_out;
  logic        Cpu_hold_out;
  logic        Busy_out;

  modport master (
    input  Prog_en_in, Sclk_in, Sdata_in,
    output Pmem_addr_out, Pmem_data_out, Pmem_we_out, Cpu_hold_out, Busy_out
  );

  modport slave (
    output Prog_en_in, Sclk_in, Sdata_in,
    input  Pmem_addr_out, Pmem_data_out, Pmem_we_out, Cpu_hold_out, Busy_out
  );
endinterface

// File: rtl/pmem_loader.sv
// ICSP-style serial loader: decodes 6-bit commands and 16-bit data frames, then
// writes 14-bit words into program memory while holding the core off the bus.
module pmem_loader #(
  parameter int PROG_CYCLES = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  pmem_loader_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] PROG = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;

  localparam logic [5:0] C_LOAD_DATA  = 6'h02;
  localparam logic [5:0] C_INC_ADDR   = 6'h06;
  localparam logic [5:0] C_RESET_ADDR = 6'h16;
  localparam logic [5:0] C_BEGIN_PROG = 6'h08;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic [SYNC_STAGES-1:0] r_pen_sync;
  logic                   r_sclk_prev;

  logic [2:0]  r_state;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_wait;
  logic [13:0] r_shift;
  logic [10:0] r_addr;
  logic [13:0] r_data;
  logic        r_we;
  logic        r_busy;

  logic       w_sclk_s;
  logic       w_sdata_s;
  logic       w_pen_s;
  logic       w_sclk_rise;
  logic [5:0] w_cmd;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdata_s   = r_sdata_sync[SYNC_STAGES-1];
  assign w_pen_s     = r_pen_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  // Oldest bit sits lowest, so the five earlier bits plus the live one form the LSB-first code.
  assign w_cmd       = {w_sdata_s, r_shift[13:9]};

  assign bus.Pmem_addr_out = r_addr;
  assign bus.Pmem_data_out = r_data;
  assign bus.Pmem_we_out   = r_we;
  assign bus.Busy_out      = r_busy;
  assign bus.Cpu_hold_out  = w_pen_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync  <= '0;
      r_sdata_sync <= '0;
      r_pen_sync   <= '0;
      r_sclk_prev  <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], bus.Sclk_in};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], bus.Sdata_in};
      r_pen_sync   <= {r_pen_sync[SYNC_STAGES-2:0], bus.Prog_en_in};
      r_sclk_prev  <= w_sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= 5'd0;
      r_wait    <= 8'd0;
      r_shift   <= 14'd0;
      r_addr    <= 11'd0;
      r_data    <= 14'd0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
    end else if (!w_pen_s) begin
      r_state   <= IDLE;
      r_bit_cnt <= 5'd0;
      r_addr    <= 11'd0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= CMD;
          r_bit_cnt <= 5'd0;
          r_addr    <= 11'd0;
        end
        CMD: begin
          if (w_sclk_rise) begin
            r_shift <= {w_sdata_s, r_shift[13:1]};
            if (r_bit_cnt == 5'd5) begin
              r_bit_cnt <= 5'd0;
              case (w_cmd)
                C_LOAD_DATA:  r_state <= DATA;
                C_INC_ADDR:   r_addr  <= r_addr + 11'd1;
                C_RESET_ADDR: r_addr  <= 11'd0;
                C_BEGIN_PROG: begin
                  r_state <= PROG;
                  r_we    <= 1'b1;
                end
                default: r_state <= CMD;
              endcase
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        DATA: begin
          if (w_sclk_rise) begin
            r_shift <= {w_sdata_s, r_shift[13:1]};
            if (r_bit_cnt == 5'd15) begin
              // Live bit is the stop bit; the register holds data bits 1..14.
              r_data    <= r_shift;
              r_bit_cnt <= 5'd0;
              r_state   <= CMD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        PROG: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b1;
          r_wait  <= 8'(PROG_CYCLES - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_wait == 8'd0) begin
            r_busy  <= 1'b0;
            r_state <= CMD;
          end else begin
            r_wait <= r_wait - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: serial command/data frames with hand-computed results.
module tb_pmem_loader;
  logic clk;
  logic rst_n;
  pmem_loader_if bus ();

  pmem_loader #(.PROG_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  int busy_cnt = 0;
  logic [10:0] last_addr = 11'd0;
  logic [13:0] last_data = 14'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe and busy monitor.
  always @(posedge clk) begin
    if (bus.Pmem_we_out) begin
      we_cnt    <= we_cnt + 1;
      last_addr <= bus.Pmem_addr_out;
      last_data <= bus.Pmem_data_out;
    end
    if (bus.Busy_out) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.Sdata_in = b;
    bus.Sclk_in  = 1'b1;
    repeat (2) @(negedge clk);
    bus.Sclk_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [5:0] c);
    for (int i = 0; i < 6; i++) send_bit(c[i]);
  endtask

  task automatic load_word(input logic [13:0] w);
    send_cmd(6'h02);
    send_bit(1'b1);
    for (int i = 0; i < 14; i++) send_bit(w[i]);
    send_bit(1'b1);
  endtask

  task automatic do_prog();
    send_cmd(6'h08);
    repeat (14) @(negedge clk);
  endtask

  int w0;
  int b0;

  initial begin
    rst_n = 1'b0;
    bus.Prog_en_in = 1'b1;
    bus.Sclk_in = 1'b0;
    bus.Sdata_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #3 bus.Sclk_in = ~bus.Sclk_in;
      bus.Sdata_in = ~bus.Sdata_in;
    end
    @(negedge clk);
    check("rst_addr", 32'(bus.Pmem_addr_out), 32'h0);
    check("rst_data", 32'(bus.Pmem_data_out), 32'h0);
    check("rst_we",   32'(bus.Pmem_we_out),   32'h0);
    check("rst_hold", 32'(bus.Cpu_hold_out),  32'h0);
    check("rst_busy", 32'(bus.Busy_out),      32'h0);
    bus.Sclk_in = 1'b0;
    bus.Sdata_in = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_after_rst", 32'(bus.Cpu_hold_out), 32'h1);
    check("state_cmd", 32'(dut.r_state), 32'(S_CMD));

    // Single write of 0x2805 at address 0.
    send_cmd(6'h16);
    load_word(14'h2805);
    check("data_2805", 32'(bus.Pmem_data_out), 32'h2805);
    w0 = we_cnt;
    b0 = busy_cnt;
    do_prog();
    check("we_count_1", 32'(we_cnt - w0), 32'd1);
    check("we_addr_1", 32'(last_addr), 32'h000);
    check("we_data_1", 32'(last_data), 32'h2805);
    check("busy_cycles", 32'(busy_cnt - b0), 32'd8);
    check("busy_low", 32'(bus.Busy_out), 32'h0);

    // Two writes at consecutive addresses.
    send_cmd(6'h16);
    load_word(14'h3400);
    do_prog();
    check("we_addr_a", 32'(last_addr), 32'h000);
    check("we_data_a", 32'(last_data), 32'h3400);
    send_cmd(6'h06);
    load_word(14'h0103);
    do_prog();
    check("we_addr_b", 32'(last_addr), 32'h001);
    check("we_data_b", 32'(last_data), 32'h0103);

    // Address wrap.
    w0 = we_cnt;
    send_cmd(6'h16);
    check("addr_reset", 32'(bus.Pmem_addr_out), 32'h000);
    for (int i = 0; i < 2047; i++) send_cmd(6'h06);
    check("addr_7ff", 32'(bus.Pmem_addr_out), 32'h7FF);
    send_cmd(6'h06);
    check("addr_wrap", 32'(bus.Pmem_addr_out), 32'h000);
    check("no_stray_we", 32'(we_cnt - w0), 32'd0);

    // Illegal command is ignored.
    send_cmd(6'h3F);
    check("illegal_state", 32'(dut.r_state), 32'(S_CMD));
    check("illegal_data", 32'(bus.Pmem_data_out), 32'h0103);
    w0 = we_cnt;
    do_prog();
    check("illegal_we_cnt", 32'(we_cnt - w0), 32'd1);
    check("illegal_we_addr", 32'(last_addr), 32'h000);
    check("illegal_we_data", 32'(last_data), 32'h0103);

    // Abort mid-frame, then reprogram.
    send_cmd(6'h06);
    check("addr_before_abort", 32'(bus.Pmem_addr_out), 32'h001);
    w0 = we_cnt;
    send_cmd(6'h02);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    @(negedge clk);
    bus.Prog_en_in = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_state", 32'(dut.r_state), 32'(S_IDLE));
    check("abort_hold", 32'(bus.Cpu_hold_out), 32'h0);
    check("abort_data", 32'(bus.Pmem_data_out), 32'h0103);
    check("abort_addr", 32'(bus.Pmem_addr_out), 32'h000);
    check("abort_no_we", 32'(we_cnt - w0), 32'd0);
    bus.Prog_en_in = 1'b1;
    repeat (4) @(negedge clk);
    check("reen_hold", 32'(bus.Cpu_hold_out), 32'h1);
    check("reen_state", 32'(dut.r_state), 32'(S_CMD));
    load_word(14'h1ABC);
    do_prog();
    check("reen_we_cnt", 32'(we_cnt - w0), 32'd1);
    check("reen_we_addr", 32'(last_addr), 32'h000);
    check("reen_we_data", 32'(last_data), 32'h1ABC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
